elastic_delay_chain: RTL and testbench



---
 rtl/edc_pkg.sv | 19 +
 rtl/edc_slice.sv | 38 +++
 rtl/elastic_delay_chain.sv | 83 ++++++++
 tb/tb_elastic_delay_chain.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edc_pkg.sv
// Shared constants and helpers for the elastic delay chain.
package edc_pkg;

  localparam int EDC_MIN_DEPTH = 1;

  // Bits needed to encode values 0..n-1; returns 0 for n<=1.
  function automatic int edc_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edc_slice.sv
// One valid/ready register slice: holds a single beat and passes it downstream.
module edc_slice
  import edc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clkB,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_bits,
  input  logic             dn_ready,
  output logic             up_ready,
  output logic             valid,
  output logic [WIDTH-1:0] bits
);

  // An empty slice always has room; a full one only if its content leaves this cycle.
  assign up_ready = !valid || dn_ready;

  always_ff @(posedge clkB or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
    end
  end

  // Payload is not reset; it is only meaningful while valid is set.
  always_ff @(posedge clkB) begin
    if (up_ready && !flush) begin
      bits <= up_bits;
    end
  end

endmodule

// File: rtl/elastic_delay_chain.sv
// DEPTH-slice back-pressurable delay chain on clkB with flush and occupancy count.
module elastic_delay_chain
  import edc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CNT_W = edc_clog2(DEPTH + 1)
) (
  input  logic             clkB,
  input  logic             reset_n,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  input  logic             io_flush,
  output logic [CNT_W-1:0] io_count
);

  if (WIDTH < 1 || DEPTH < EDC_MIN_DEPTH) begin : g_bad_params
    $error("elastic_delay_chain: WIDTH and DEPTH must both be >= 1");
  end

  // Handshake: a beat moves across any boundary exactly on an edge where valid
  // and ready are both high; valid never depends on ready, ready may depend on valid.

  // Element k is the upstream side of slice k; element DEPTH is io_out.
  logic             chain_v [DEPTH+1];
  logic [WIDTH-1:0] chain_d [DEPTH+1];
  logic             nv      [DEPTH];
  logic [CNT_W-1:0] cnt_next;

  assign chain_v[0]   = io_in_valid;
  assign chain_d[0]   = io_in_bits;
  assign io_out_valid = chain_v[DEPTH];
  assign io_out_bits  = chain_d[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic up_rdy;
    logic dn_rdy;

    if (k == DEPTH - 1) begin : g_last
      assign dn_rdy = io_out_ready;
    end else begin : g_mid
      assign dn_rdy = g_slice[k+1].up_rdy;
    end

    edc_slice #(.WIDTH(WIDTH)) u_slice (
      .clkB     (clkB),
      .reset_n  (reset_n),
      .flush    (io_flush),
      .up_valid (chain_v[k]),
      .up_bits  (chain_d[k]),
      .dn_ready (dn_rdy),
      .up_ready (up_rdy),
      .valid    (chain_v[k+1]),
      .bits     (chain_d[k+1])
    );

    // Mirror of the slice's next valid, used only for the occupancy count.
    assign nv[k] = !io_flush && (up_rdy ? chain_v[k] : chain_v[k+1]);
  end

  // Blocking intake during flush keeps a beat from being swallowed by the clear.
  assign io_in_ready = g_slice[0].up_rdy && !io_flush;

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_next = cnt_next + CNT_W'(nv[k]);
    end
  end

  always_ff @(posedge clkB or negedge reset_n) begin
    if (!reset_n) begin
      io_count <= '0;
    end else begin
      io_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_elastic_delay_chain.sv
// Directed and random checks of elastic_delay_chain against a FIFO scoreboard and count model.
module tb_elastic_delay_chain;

  logic clkB = 1'b0;
  logic reset_n;
  always #5 clkB = ~clkB;

  // dut_a: WIDTH=8 DEPTH=3 (directed)
  logic       a_iv, a_ir, a_ov, a_or, a_fl;
  logic [7:0] a_ib, a_ob;
  logic [1:0] a_cnt;
  // dut_b: WIDTH=1 DEPTH=1 (random)
  logic       b_iv, b_ir, b_ov, b_or, b_fl;
  logic [0:0] b_ib, b_ob;
  logic [0:0] b_cnt;
  // dut_c: WIDTH=32 DEPTH=4 (random)
  logic        c_iv, c_ir, c_ov, c_or, c_fl;
  logic [31:0] c_ib, c_ob;
  logic [2:0]  c_cnt;

  elastic_delay_chain #(.WIDTH(8), .DEPTH(3)) dut_a (
    .clkB(clkB), .reset_n(reset_n), .io_in_valid(a_iv), .io_in_ready(a_ir), .io_in_bits(a_ib),
    .io_out_valid(a_ov), .io_out_ready(a_or), .io_out_bits(a_ob), .io_flush(a_fl), .io_count(a_cnt));
  elastic_delay_chain #(.WIDTH(1), .DEPTH(1)) dut_b (
    .clkB(clkB), .reset_n(reset_n), .io_in_valid(b_iv), .io_in_ready(b_ir), .io_in_bits(b_ib),
    .io_out_valid(b_ov), .io_out_ready(b_or), .io_out_bits(b_ob), .io_flush(b_fl), .io_count(b_cnt));
  elastic_delay_chain #(.WIDTH(32), .DEPTH(4)) dut_c (
    .clkB(clkB), .reset_n(reset_n), .io_in_valid(c_iv), .io_in_ready(c_ir), .io_in_bits(c_ib),
    .io_out_valid(c_ov), .io_out_ready(c_or), .io_out_bits(c_ob), .io_flush(c_fl), .io_count(c_cnt));

  // Scoreboard state
  int          n_pass = 0;
  int          n_checks = 0;
  logic [7:0]  q_a[$];
  logic [0:0]  q_b[$];
  logic [31:0] q_c[$];
  int          m_a, m_b, m_c;
  int          cyc;
  int          cons_at[$];
  logic        last_acc;
  int          s, idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Each eval_* runs #1 after the falling edge with inputs stable, before the next rising edge.
  task automatic eval_a();
    logic er, acc, cons;
    er = !a_fl && (a_or || m_a < 3);
    check("a_in_ready", 32'(a_ir), 32'(er));
    check("a_count", 32'(a_cnt), 32'(m_a));
    cons = 1'b0;
    if (a_ov && a_or) begin
      cons = 1'b1;
      cons_at.push_back(cyc);
      if (q_a.size() == 0) check("a_out_valid_empty", 32'(a_ov), 32'(0));
      else check("a_out_bits", 32'(a_ob), 32'(q_a.pop_front()));
    end
    acc = a_iv && a_ir;
    last_acc = acc;
    if (acc) q_a.push_back(a_ib);
    if (a_fl) begin
      q_a.delete();
      m_a = 0;
    end else begin
      m_a = m_a + int'(acc) - int'(cons);
    end
    cyc++;
  endtask

  task automatic eval_b();
    logic er, acc, cons;
    er = !b_fl && (b_or || m_b < 1);
    check("b_in_ready", 32'(b_ir), 32'(er));
    check("b_count", 32'(b_cnt), 32'(m_b));
    cons = 1'b0;
    if (b_ov && b_or) begin
      cons = 1'b1;
      if (q_b.size() == 0) check("b_out_valid_empty", 32'(b_ov), 32'(0));
      else check("b_out_bits", 32'(b_ob), 32'(q_b.pop_front()));
    end
    acc = b_iv && b_ir;
    if (acc) q_b.push_back(b_ib);
    if (b_fl) begin
      q_b.delete();
      m_b = 0;
    end else begin
      m_b = m_b + int'(acc) - int'(cons);
    end
  endtask

  task automatic eval_c();
    logic er, acc, cons;
    er = !c_fl && (c_or || m_c < 4);
    check("c_in_ready", 32'(c_ir), 32'(er));
    check("c_count", 32'(c_cnt), 32'(m_c));
    cons = 1'b0;
    if (c_ov && c_or) begin
      cons = 1'b1;
      if (q_c.size() == 0) check("c_out_valid_empty", 32'(c_ov), 32'(0));
      else check("c_out_bits", c_ob, q_c.pop_front());
    end
    acc = c_iv && c_ir;
    if (acc) q_c.push_back(c_ib);
    if (c_fl) begin
      q_c.delete();
      m_c = 0;
    end else begin
      m_c = m_c + int'(acc) - int'(cons);
    end
  endtask

  task automatic step_a(input logic iv, input logic [7:0] ib, input logic ordy, input logic fl);
    @(negedge clkB);
    a_iv = iv;
    a_ib = ib;
    a_or = ordy;
    a_fl = fl;
    #1;
    eval_a();
  endtask

  task automatic clear_models();
    q_a.delete();
    q_b.delete();
    q_c.delete();
    m_a = 0;
    m_b = 0;
    m_c = 0;
  endtask

  initial begin
    // Reset values without any clock edge
    reset_n = 1'b0;
    a_iv = 0; a_ib = '0; a_or = 0; a_fl = 0;
    b_iv = 0; b_ib = '0; b_or = 0; b_fl = 0;
    c_iv = 0; c_ib = '0; c_or = 0; c_fl = 0;
    clear_models();
    cyc = 0;
    #1;
    check("rst_out_valid", 32'(a_ov), 32'(0));
    check("rst_count", 32'(a_cnt), 32'(0));
    check("rst_in_ready", 32'(a_ir), 32'(1));
    check("rst_c_out_valid", 32'(c_ov), 32'(0));
    @(negedge clkB);
    reset_n = 1'b1;

    // Mid-cycle asynchronous reset with beats in flight
    step_a(1, 8'h11, 0, 0);
    step_a(1, 8'h12, 0, 0);
    step_a(0, 8'h00, 0, 0);
    a_iv = 0;
    @(posedge clkB);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(a_ov), 32'(0));
    check("midrst_count", 32'(a_cnt), 32'(0));
    check("midrst_in_ready", 32'(a_ir), 32'(1));
    clear_models();
    @(negedge clkB);
    reset_n = 1'b1;

    // Streaming 0x01..0x10 with the consumer always ready
    cons_at.delete();
    s = cyc;
    for (int i = 0; i < 16; i++) step_a(1, 8'(i + 1), 1, 0);
    for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0);
    check("stream_beats", 32'(cons_at.size()), 32'(16));
    for (int i = 0; i < 16 && i < cons_at.size(); i++)
      check("stream_cycle", 32'(cons_at[i]), 32'(s + 3 + i));
    check("stream_drained", 32'(q_a.size()), 32'(0));

    // Fill against a stalled consumer, then release for one cycle
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step_a(1, 8'(8'h30 + idx), 0, 0);
      if (last_acc) idx++;
    end
    check("fill_accepted", 32'(idx), 32'(3));
    check("fill_in_ready", 32'(a_ir), 32'(0));
    check("fill_count", 32'(a_cnt), 32'(3));
    step_a(1, 8'(8'h30 + idx), 1, 0);
    check("fill_release_acc", 32'(last_acc), 32'(1));
    step_a(0, 8'h00, 0, 0);
    check("fill_count_hold", 32'(a_cnt), 32'(3));
    for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0);
    check("fill_drained", 32'(q_a.size()), 32'(0));

    // Bubbles collapse once the consumer stalls
    step_a(1, 8'h41, 1, 0);
    step_a(0, 8'h00, 1, 0);
    step_a(1, 8'h42, 0, 0);
    step_a(0, 8'h00, 0, 0);
    check("bubble_cnt2", 32'(a_cnt), 32'(2));
    step_a(1, 8'h43, 0, 0);
    step_a(0, 8'h00, 0, 0);
    check("bubble_cnt3", 32'(a_cnt), 32'(3));
    for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0);
    check("bubble_drained", 32'(q_a.size()), 32'(0));

    // Flush a full chain while a new beat is offered
    step_a(1, 8'hA1, 0, 0);
    step_a(1, 8'hA2, 0, 0);
    step_a(1, 8'hA3, 0, 0);
    step_a(1, 8'hB0, 0, 1);
    check("flush_in_ready", 32'(a_ir), 32'(0));
    step_a(0, 8'h00, 0, 0);
    check("flush_count", 32'(a_cnt), 32'(0));
    check("flush_out_valid", 32'(a_ov), 32'(0));
    for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0);
    check("flush_no_leak", 32'(q_a.size()), 32'(0));

    // Random valid/ready/flush on the WIDTH=1/DEPTH=1 and WIDTH=32/DEPTH=4 chains
    for (int i = 0; i < 10000; i++) begin
      @(negedge clkB);
      b_iv = 1'($urandom_range(0, 1));
      b_ib = 1'($urandom_range(0, 1));
      b_or = 1'($urandom_range(0, 1));
      b_fl = ($urandom_range(0, 63) == 0);
      c_iv = 1'($urandom_range(0, 1));
      c_ib = $urandom;
      c_or = ($urandom_range(0, 3) != 0);
      c_fl = ($urandom_range(0, 63) == 0);
      #1;
      eval_b();
      eval_c();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clkB);
      b_iv = 0; b_or = 1; b_fl = 0;
      c_iv = 0; c_or = 1; c_fl = 0;
      #1;
      eval_b();
      eval_c();
    end
    check("rand_b_drained", 32'(q_b.size()), 32'(0));
    check("rand_c_drained", 32'(q_c.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
